// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: shares one synchronous single-port RAM between the fetch and data ports
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_rdata/i_ack          instruction fetch port
//   d_req/d_we/d_be/d_addr/d_wdata -> d_rdata/d_ack   data port
//   stall                                  combinational core stall
//   ram_addr/ram_wren/ram_byteena/ram_wdata -> RAM, ram_q <- RAM (RD_LAT cycles after address edge)
module unified_mem_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RAM_AW   = 10,
  parameter int RD_LAT   = 1,
  parameter int DATA_PRI = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                stall,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [DATA_W/8-1:0] ram_byteena,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_q
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;
  localparam logic [1:0] LAST  = 2'(RD_LAT - 1);
  logic [1:0] state;
  logic [1:0] cnt;
  logic pri_d;
  logic gnt_d;
  logic we_q;
  logic sel_d;
  logic sel_we;
  logic in_rng;
  logic [ADDR_W-1:0] sel_addr;
  logic unused_addr_lsbs;
  // pri_d set means the data port wins a tie
  assign sel_d    = d_req & (~i_req | pri_d);
  assign sel_we   = sel_d & d_we;
  assign sel_addr = sel_d ? d_addr : i_addr;
  assign in_rng   = sel_addr[ADDR_W-1:RAM_AW+2] == '0;
  assign stall    = (i_req & ~i_ack) | (d_req & ~d_ack);
  assign unused_addr_lsbs = ^sel_addr[1:0];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pri_d       <= 1'b1;
      gnt_d       <= 1'b0;
      we_q        <= 1'b0;
      ram_addr    <= '0;
      ram_wren    <= 1'b0;
      ram_byteena <= '0;
      ram_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_ack       <= 1'b0;
      d_ack       <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE:
          if (i_req | d_req) begin
            gnt_d <= sel_d;
            we_q  <= sel_we;
            pri_d <= DATA_PRI != 0 ? 1'b1 : ~sel_d;
            if (in_rng) begin
              state       <= ISSUE;
              ram_addr    <= sel_addr[RAM_AW+1:2];
              ram_wren    <= sel_we;
              ram_byteena <= sel_we ? d_be : '1;
              ram_wdata   <= d_wdata;
            end else begin
              // out-of-range: no RAM cycle, reads complete with zero, writes are dropped
              state <= ACK;
              i_ack <= ~sel_d;
              d_ack <= sel_d;
              if (!sel_we && sel_d) d_rdata <= '0;
              if (!sel_d) i_rdata <= '0;
            end
          end
        ISSUE: begin
          ram_wren    <= 1'b0;
          ram_byteena <= '0;
          cnt         <= '0;
          state       <= we_q ? ACK : WAIT;
          d_ack       <= we_q;
        end
        WAIT: begin
          cnt <= cnt + 2'd1;
          if (cnt == LAST) begin
            state <= ACK;
            i_ack <= ~gnt_d;
            d_ack <= gnt_d;
            if (gnt_d) d_rdata <= ram_q;
            else i_rdata <= ram_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: scoreboard bench for two controller configurations with RAM models
module tb_unified_mem_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic        i_req[2], d_req[2], d_we[2], i_ack[2], d_ack[2], stall[2], ram_wren[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2], i_rdata[2], d_rdata[2], ram_wdata[2], ram_q[2];
  logic [3:0]  d_be[2], ram_byteena[2];
  logic [9:0]  ram_addr[2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // instance 0: RD_LAT=2, fixed data priority; instance 1: RD_LAT=1, alternating priority
  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = (k == 0) ? 2 : 1;
    logic [31:0] mem [1024];
    logic [31:0] pipe [4];
    unified_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .RAM_AW(10), .RD_LAT(L), .DATA_PRI((k == 0) ? 1 : 0)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req[k]), .i_addr(i_addr[k]), .i_rdata(i_rdata[k]), .i_ack(i_ack[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_be(d_be[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_rdata(d_rdata[k]), .d_ack(d_ack[k]), .stall(stall[k]),
      .ram_addr(ram_addr[k]), .ram_wren(ram_wren[k]), .ram_byteena(ram_byteena[k]),
      .ram_wdata(ram_wdata[k]), .ram_q(ram_q[k])
    );
    always @(posedge clk) begin
      if (ram_wren[k])
        for (int b = 0; b < 4; b++)
          if (ram_byteena[k][b]) mem[ram_addr[k]][8*b +: 8] <= ram_wdata[k][8*b +: 8];
      pipe[0] <= mem[ram_addr[k]];
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
    end
    assign ram_q[k] = pipe[L-1];
  end
  typedef struct {
    int k;
    int p;
    logic [31:0] data;
    int c;
  } exp_t;
  exp_t sb[$];
  int wr_cnt[2], wr_cyc[2];
  logic [9:0] wr_addr[2];
  logic [3:0] wr_be[2];
  logic [31:0] wr_data[2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (ram_wren[k]) begin
        wr_cnt[k]++;
        wr_cyc[k]  = cyc;
        wr_addr[k] = ram_addr[k];
        wr_be[k]   = ram_byteena[k];
        wr_data[k] = ram_wdata[k];
      end
  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        logic a;
        logic [31:0] r;
        exp_t e;
        a = (p == 1) ? d_ack[k] : i_ack[k];
        r = (p == 1) ? d_rdata[k] : i_rdata[k];
        if (a) begin
          if (sb.size() == 0) chk("unexpected_ack", k*2 + p, 32'hffff_ffff);
          else begin
            e = sb.pop_front();
            chk("ack_port", k*2 + p, e.k*2 + e.p);
            chk("ack_cycle", cyc, e.c);
            chk("rdata", r, e.data);
          end
        end
      end
  task automatic push(input int k, input int p, input logic [31:0] d, input int c);
    exp_t e;
    e.k = k; e.p = p; e.data = d; e.c = c;
    sb.push_back(e);
  endtask
  task automatic xfer(input int k, input int p, input logic we, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    if (p == 1) begin
      d_we[k] = we; d_be[k] = be; d_addr[k] = a; d_wdata[k] = wd; d_req[k] = 1'b1;
    end else begin
      i_addr[k] = a; i_req[k] = 1'b1;
    end
    do begin
      @(negedge clk);
      n++;
    end while (!((p == 1) ? d_ack[k] : i_ack[k]) && n < 40);
    chk("ack_seen", 32'((p == 1) ? d_ack[k] : i_ack[k]), 32'd1);
    @(posedge clk);
    #1;
    if (p == 1) d_req[k] = 1'b0;
    else i_req[k] = 1'b0;
  endtask
  task automatic rd(input int k, input int p, input logic [31:0] a, input logic [31:0] exp, input int lat);
    push(k, p, exp, cyc + lat);
    xfer(k, p, 1'b0, 4'h0, a, 32'h0);
  endtask
  task automatic wr_chk(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic [31:0] keep);
    int s = cyc;
    int c0 = wr_cnt[k];
    push(k, 1, keep, s + 2);
    xfer(k, 1, 1'b1, be, a, d);
    chk("wr_count", wr_cnt[k] - c0, 32'd1);
    chk("wr_cycle", wr_cyc[k], s + 1);
    chk("wr_addr", 32'(wr_addr[k]), a >> 2);
    chk("wr_be", 32'(wr_be[k]), 32'(be));
    chk("wr_data", wr_data[k], d);
  endtask
  task automatic chk_rst(input int k);
    chk("rst_ram_addr", 32'(ram_addr[k]), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren[k]), 32'd0);
    chk("rst_ram_be", 32'(ram_byteena[k]), 32'd0);
    chk("rst_ram_wdata", ram_wdata[k], 32'd0);
    chk("rst_i_rdata", i_rdata[k], 32'd0);
    chk("rst_d_rdata", d_rdata[k], 32'd0);
    chk("rst_i_ack", 32'(i_ack[k]), 32'd0);
    chk("rst_d_ack", 32'(d_ack[k]), 32'd0);
    chk("rst_stall", 32'(stall[k]), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int s;
    int c0;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 0; d_req[k] = 0; d_we[k] = 0; d_be[k] = 0;
      i_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    repeat (3) @(negedge clk);
    chk_rst(0);
    chk_rst(1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // instance 1 (RD_LAT=1, alternating priority)
    wr_chk(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    rd(1, 1, 32'h10, 32'hDEADBEEF, 3);
    wr_chk(1, 32'h10, 32'h0000AB00, 4'b0010, 32'hDEADBEEF);
    rd(1, 1, 32'h10, 32'hDEADABEF, 3);
    wr_chk(1, 32'h0, 32'h12345678, 4'hF, 32'hDEADABEF);
    c0 = wr_cnt[1];
    rd(1, 1, 32'h0000_1000, 32'h0, 1);
    push(1, 1, 32'h0, cyc + 1);
    xfer(1, 1, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFFFFFF);
    rd(1, 0, 32'h8000_0000, 32'h0, 1);
    chk("oor_no_write", wr_cnt[1] - c0, 32'd0);
    rd(1, 1, 32'h0, 32'h12345678, 3);
    rd(1, 0, 32'h13, 32'hDEADABEF, 3);
    wr_chk(1, 32'h40, 32'hA0A0A0A0, 4'hF, 32'h12345678);
    wr_chk(1, 32'h44, 32'hB1B1B1B1, 4'hF, 32'h12345678);
    // last grant was data, so the first tie goes to fetch
    s = cyc;
    push(1, 0, 32'hA0A0A0A0, s + 3);
    push(1, 1, 32'hDEADABEF, s + 7);
    push(1, 0, 32'hB1B1B1B1, s + 11);
    push(1, 1, 32'h12345678, s + 15);
    fork
      begin
        xfer(1, 0, 1'b0, 4'h0, 32'h40, 32'h0);
        xfer(1, 0, 1'b0, 4'h0, 32'h44, 32'h0);
      end
      begin
        xfer(1, 1, 1'b0, 4'h0, 32'h10, 32'h0);
        xfer(1, 1, 1'b0, 4'h0, 32'h00, 32'h0);
      end
    join
    // instance 0 (RD_LAT=2, data priority)
    wr_chk(0, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0);
    wr_chk(0, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0);
    rd(0, 1, 32'h10, 32'hDEADBEEF, 4);
    s = cyc;
    push(0, 1, 32'hDEADBEEF, s + 4);
    push(0, 0, 32'hCAFEF00D, s + 9);
    fork
      xfer(0, 1, 1'b0, 4'h0, 32'h10, 32'h0);
      xfer(0, 0, 1'b0, 4'h0, 32'h20, 32'h0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        chk("stall", 32'(stall[0]), 32'(c < 9));
      end
    join
    // previous grant was fetch; fixed priority still gives data the tie
    s = cyc;
    push(0, 1, 32'hDEADBEEF, s + 2);
    push(0, 0, 32'hDEADBEEF, s + 7);
    fork
      xfer(0, 1, 1'b1, 4'hF, 32'h30, 32'h55AA55AA);
      xfer(0, 0, 1'b0, 4'h0, 32'h10, 32'h0);
    join
    rd(0, 1, 32'h30, 32'h55AA55AA, 4);
    // reset in the middle of a read's WAIT phase
    d_we[0] = 1'b0; d_addr[0] = 32'h20; d_req[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_addr", 32'(ram_addr[0]), 32'd0);
    chk("rst_mid_i_rdata", i_rdata[0], 32'd0);
    chk("rst_mid_d_rdata", d_rdata[0], 32'd0);
    chk("rst_mid_d_ack", 32'(d_ack[0]), 32'd0);
    chk("rst_mid_wren", 32'(ram_wren[0]), 32'd0);
    d_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    rd(0, 0, 32'h10, 32'hDEADBEEF, 4);
    repeat (6) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/unified_mem_ctrl.md
Name: unified_mem_ctrl

Overview:
- Single-port memory controller that lets the processor's instruction-fetch port and data port share one synchronous RAM (one unified memory instead of separate instruction and data memories).
- Arbitrates between the two requesters, sequences multi-cycle RAM reads of configurable latency and byte-enabled writes, and drives a stall to the core.
- Sits between the processor core and the RAM IP (clock/wren/address/byteena/data/q interface).

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 32, byte-address width of the requester ports.
- RAM_AW, 10, RAM word-address width (RAM depth is 2**RAM_AW words).
- RD_LAT, 1, RAM read latency in cycles, from the clock edge that samples the address to q valid; legal range 1..4.
- DATA_PRI, 1, 1 = data port always wins ties; 0 = alternating priority (the port granted last loses the next tie).

Ports:
- clk  in  1  clock; everything is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held with a stable address until i_ack.
- i_addr  in  ADDR_W  fetch byte address.
- i_rdata  out  DATA_W  fetched word.
- i_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DATA_W/8  byte enables for writes.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data.
- d_ack  out  1  one-cycle completion pulse for data.
- stall  out  1  core stall.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wren  out  1  RAM write enable.
- ram_byteena  out  DATA_W/8  RAM byte enables.
- ram_wdata  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data.

Behaviour:
- Reset values (asynchronous, while reset=0): state IDLE; ram_wren=0; ram_addr, ram_byteena, ram_wdata, i_rdata, d_rdata all 0; i_ack=0; d_ack=0; priority pointer set to data.
- States: IDLE, ISSUE, WAIT, ACK. All ram_* outputs, acks and rdata are registered.
- IDLE:
  - Samples i_req and d_req. If both are high, the winner follows DATA_PRI; the loser stays pending.
  - Latches the winner's address, we, be and wdata.
  - In-range access → ISSUE. Out-of-range access → ACK.
- Address map: word index = addr[RAM_AW+1:2]. In range iff addr[ADDR_W-1:RAM_AW+2]==0. addr[1:0] is ignored.
- Out-of-range access: no RAM activity. Reads return rdata=0; writes are dropped. Ack is still given, in cycle 1.
- ISSUE (cycle 1 after grant): ram_addr is valid.
  - Write: ram_wren=1, ram_byteena=d_be, ram_wdata=d_wdata, for exactly this cycle; next state ACK.
  - Read: ram_wren=0, ram_byteena=all ones; next state WAIT.
- WAIT: a counter runs RD_LAT cycles. On the last WAIT cycle, ram_q is captured into the granted port's rdata register; next state ACK.
- ACK: the granted port's ack is high for exactly one cycle; next state IDLE.
  - Requests seen during ACK are ignored. A req still high in the following IDLE cycle is a new request.
- Latency, measured from the grant cycle (cycle 0):
  - In-range write: ack in cycle 2.
  - In-range read: ack in cycle 2+RD_LAT, rdata valid in that same cycle.
  - Out-of-range access: ack in cycle 1.
- rdata registers hold their value until the next read completion on the same port. Write acks leave d_rdata unchanged.
- stall is combinational: (i_req & ~i_ack) | (d_req & ~d_ack).
- Simultaneous requests:
  - DATA_PRI=1: data is served first; fetch is granted in the IDLE cycle after the data ack.
  - DATA_PRI=0: the pointer toggles to the other port on every grant.
- Only one access is in flight at a time. No reordering.
- Reset mid-operation: ram_wren drops immediately; a write in ISSUE may or may not commit; no ack is issued for the aborted access.
- Requester protocol violations (changing addr or req before ack) are undefined.

Test Plan:
- Write d_addr=0x10, d_wdata=0xDEADBEEF, d_be=4'hF → ram_wren=1, ram_addr=4 in cycle 1; d_ack in cycle 2. Then read 0x10 with RD_LAT=1 → d_ack in cycle 3, d_rdata=0xDEADBEEF.
- d_be=4'b0010 write of 0x0000AB00 over 0xDEADBEEF → ram_byteena=0010 in ISSUE only; readback gives 0xDEADABEF.
- i_req and d_req both high at IDLE, DATA_PRI=1, RD_LAT=2 → d_ack in cycle 4, i granted in cycle 5, i_ack in cycle 9; stall high through cycle 8.
- DATA_PRI=0 with both requests held continuously for four grants → grants alternate i,d,i,d; neither port waits more than one access.
- d_addr=0x0000_1000 (out of range for RAM_AW=10) read → no ram activity, d_ack in cycle 1, d_rdata=0. The same address as a write → RAM contents unchanged.
- Assert reset=0 during WAIT of a read → all outputs 0 immediately, no ack. After release, a new i_req completes normally with the correct data.
